// File: rtl/alu_sched_pkg.sv
// Shared types and encodings for the ALU scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_sched_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Captured response payload, held stable while rsp_valid is high.
  typedef struct packed {
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        ovf;
    logic        err;
  } rsp_t;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; owns the last-granted pointer.
// Latency: grant is combinational from req; pointer updates on the accepting edge.
// Backpressure: pointer only advances when accept is high with a grant present.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_q, last_d;

  // Grant a lone requester outright; on contention favour the one not granted last.
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    gnt_id = gnt[1];
    if (accept && (gnt != 2'b00)) begin
      last_d = gnt_id;
    end
  end

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Schedules two requesters onto one shared combinational ALU, one op in flight.
// Latency: accept on edge T -> rsp_valid from edge T+SETTLE (SETTLE legal 1..15).
// Backpressure: response held until rsp_ready; no request accepted outside IDLE.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  input  logic        alu_zero,
  input  logic        alu_set,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_cout,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             id_q, id_d;
  rsp_t             rsp_q, rsp_d;

  logic [1:0]       arb_req, gnt;
  logic             gnt_id, accept;

  // Requests only reach the arbiter in IDLE, so grants are zero while busy.
  assign arb_req = {req1_valid, req0_valid} & {2{state_q == IDLE}};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .accept (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Readys are forced low while reset is asserted so nothing looks accepted during reset.
  assign req0_ready = gnt[0] & rst_n;
  assign req1_ready = gnt[1] & rst_n;

  // Next-state: accept in IDLE, count down the settle window, capture, then hold for the consumer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    id_d     = id_q;
    rsp_d    = rsp_q;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          accept   = 1'b1;
          alu_a_d  = gnt_id ? req1_a  : req0_a;
          alu_b_d  = gnt_id ? req1_b  : req0_b;
          alu_op_d = gnt_id ? req1_op : req0_op;
          cnt_d    = CNT_W'(SETTLE - 1);
          id_d     = gnt_id;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
          if (!op_legal(alu_op_q)) begin
            rsp_d = '{result: 32'd0, cout: 1'b0, zero: 1'b0, ovf: 1'b0, err: 1'b1};
          end else begin
            rsp_d.result = (alu_op_q == OP_SLT) ? {31'd0, alu_set} : alu_result;
            rsp_d.cout   = alu_cout;
            rsp_d.zero   = alu_zero;
            rsp_d.ovf    = alu_ovf;
            rsp_d.err    = 1'b0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and response registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      id_q     <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      id_q     <= id_d;
      rsp_q    <= rsp_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = rsp_q.result;
  assign rsp_cout   = rsp_q.cout;
  assign rsp_zero   = rsp_q.zero;
  assign rsp_ovf    = rsp_q.ovf;
  assign rsp_err    = rsp_q.err;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural model of the shared ALU.
// Latency: checks accept-to-response of SETTLE cycles.
// Backpressure: holds rsp_ready low and checks the response and readys stay put.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_cout, alu_zero, alu_set, alu_ovf;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_cout, rsp_zero, rsp_ovf, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_sched #(.SETTLE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .alu_set(alu_set), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );

  // Behavioural ALU; illegal ops drive junk so the scheduler's masking is visible.
  logic [32:0] m_sum;
  always_comb begin
    m_sum      = 33'd0;
    alu_result = 32'd0;
    alu_cout   = 1'b0;
    alu_ovf    = 1'b0;
    alu_set    = 1'b0;
    alu_zero   = 1'b0;
    case (alu_op)
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_ADD: begin
        m_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = m_sum[31:0];
        alu_cout   = m_sum[32];
        alu_ovf    = (alu_a[31] == alu_b[31]) && (m_sum[31] != alu_a[31]);
      end
      OP_SUB, OP_SLT: begin
        m_sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_cout   = m_sum[32];
        alu_ovf    = (alu_a[31] != alu_b[31]) && (m_sum[31] != alu_a[31]);
        alu_set    = m_sum[31] ^ alu_ovf;
        alu_result = (alu_op == OP_SLT) ? {31'd0, alu_set} : m_sum[31:0];
      end
      default: begin
        alu_result = 32'hDEAD_BEEF;
        alu_cout   = 1'b1;
        alu_ovf    = 1'b1;
        alu_set    = 1'b1;
      end
    endcase
    if (alu_op != 3'b011 && alu_op != 3'b100 && alu_op != 3'b101) begin
      alu_zero = (alu_result == 32'd0);
    end else begin
      alu_zero = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request, wait for its acceptance, then count edges until the response.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, output int lat, output bit leak);
    bit acc = 1'b0;
    bit got = 1'b0;
    lat  = 0;
    leak = 1'b0;
    @(negedge clk);
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
    for (int i = 0; i < 40 && !acc; i++) begin
      #1;
      if ((id == 0) ? req0_ready : req1_ready) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (req0_ready || req1_ready) leak = 1'b1;
      if (rsp_valid) got = 1'b1;
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  int       lat;
  bit       leak, bad, got;
  int       grants[$];
  int       rids[$];
  logic [31:0] rres[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_ADD;
    req1_a = 32'd0; req1_b = 32'd0; req1_op = OP_AND;
    repeat (2) @(negedge clk);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ADD latency and basic response
    issue(0, 32'd5, 32'd7, OP_ADD, lat, leak);
    chk("add_lat", 32'(lat), 32'd4);
    chk("add_id", {31'd0, rsp_id}, 32'd0);
    chk("add_res", rsp_result, 32'd12);
    chk("add_zero", {31'd0, rsp_zero}, 32'd0);
    chk("add_err", {31'd0, rsp_err}, 32'd0);
    chk("add_ready_low", {31'd0, leak}, 32'd0);
    consume();

    issue(1, 32'd7891932, 32'd318902, OP_SUB, lat, leak);
    chk("sub_id", {31'd0, rsp_id}, 32'd1);
    chk("sub_res", rsp_result, 32'd7573030);
    consume();

    issue(0, 32'd65512, 32'd65512, OP_SUB, lat, leak);
    chk("subz_res", rsp_result, 32'd0);
    chk("subz_zero", {31'd0, rsp_zero}, 32'd1);
    consume();

    issue(1, 32'h7FFF_FFFF, 32'd1, OP_ADD, lat, leak);
    chk("ovf_res", rsp_result, 32'h8000_0000);
    chk("ovf_flag", {31'd0, rsp_ovf}, 32'd1);
    consume();

    issue(0, -32'sd123213, 32'd412412, OP_SLT, lat, leak);
    chk("slt_res", rsp_result, 32'd1);
    chk("slt_err", {31'd0, rsp_err}, 32'd0);
    consume();

    issue(1, 32'd9, 32'd3, 3'b011, lat, leak);
    chk("ill_res", rsp_result, 32'd0);
    chk("ill_err", {31'd0, rsp_err}, 32'd1);
    chk("ill_flags", {29'd0, rsp_cout, rsp_zero, rsp_ovf}, 32'd0);
    consume();

    // Backpressure: response held while req1 waits
    issue(0, 32'd3, 32'd4, OP_ADD, lat, leak);
    req1_a = 32'd10; req1_b = 32'd4; req1_op = OP_SUB; req1_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_result !== 32'd7 || rsp_valid !== 1'b1 || rsp_id !== 1'b0 || req1_ready !== 1'b0)
        bad = 1'b1;
    end
    chk("bp_hold", {31'd0, bad}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    chk("bp_rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("bp_rsp_seen", {31'd0, got}, 32'd1);
    chk("bp_res", rsp_result, 32'd6);
    chk("bp_id", {31'd0, rsp_id}, 32'd1);
    consume();

    // Contention after reset: strict alternation starting with req0
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_a = 32'd512312; req0_b = 32'd312312; req0_op = OP_AND;
    req1_a = 32'd512312; req1_b = 32'd312312; req1_op = OP_OR;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 100 && rids.size() < 4; i++) begin
      #1;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid) begin
        rids.push_back(int'(rsp_id));
        rres.push_back(rsp_result);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    chk("rr_count", 32'(rids.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    for (int i = 0; i < 4 && i < rids.size(); i++) begin
      chk($sformatf("rr_id%0d", i), 32'(rids[i]), 32'(i % 2));
      chk($sformatf("rr_res%0d", i), rres[i], (i % 2 == 0) ? 32'd311608 : 32'd513016);
    end

    // Reset mid-EXEC with both requesters pending
    @(negedge clk);
    req0_a = 32'd1; req0_b = 32'd2; req0_op = OP_ADD; req0_valid = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req0_a = 32'd10;  req0_b = 32'd20;  req0_op = OP_ADD; req0_valid = 1'b1;
    req1_a = 32'd100; req1_b = 32'd200; req1_op = OP_ADD; req1_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_zero, rsp_ovf, rsp_err}, 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_res", rsp_result, 32'd30);
    chk("post_rst_id", {31'd0, rsp_id}, 32'd0);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler for the shared 32-bit gate-level ALU (AND/OR/ADD/SUB/SLT, with cout/zero/set/overflow flags). Requesters use valid/ready handshakes. The block arbitrates round-robin, drives the ALU from registered operands, and waits a fixed settle time because the ALU is a multi-gate-delay combinational path. It then captures the result and flags into a single response port tagged with the requester id, and holds them until consumed. One operation is in flight at a time.

## Interface
- SETTLE, 4, cycles the ALU inputs are held before outputs are captured; legal range 1..15.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  32  operands (two's complement)
- req0_op / req1_op  in  3  op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- alu_a, alu_b  out  32  registered operands to ALU
- alu_op  out  3  registered op to ALU
- alu_result  in  32  ALU result
- alu_cout, alu_zero, alu_set, alu_ovf  in  1  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_id  out  1  granted requester (0/1)
- rsp_result  out  32  captured result
- rsp_cout, rsp_zero, rsp_ovf  out  1  captured flags
- rsp_err  out  1  op was not one of the five legal encodings

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - If any reqN_valid is high, the arbiter grants one requester.
  - reqN_ready is asserted combinationally, for the granted requester only.
  - On the accepting edge: latch a, b and op into the alu_* registers, set cnt=SETTLE-1, record the id, go to EXEC.
- **EXEC**
  - alu_* stay stable.
  - Each cycle with cnt≠0: cnt decrements.
  - On the edge with cnt==0, capture the response registers and go to RESP:
    - Ops 000/001/010/110: rsp_result=alu_result.
    - Op 111: rsp_result={31'b0, alu_set}.
    - Any other op: rsp_result=0, rsp_err=1, and all flags are 0.
    - Legal ops: rsp_cout, rsp_zero and rsp_ovf come from the ALU; rsp_err=0.
- **RESP**
  - rsp_valid=1. All rsp_* stay stable until rsp_valid && rsp_ready, then go to IDLE.
  - No request is accepted in EXEC or RESP; both readys are 0.
- **Arbitration** (2-way round-robin)
  - The last-granted pointer resets to 1, so req0 wins the first contention.
  - If only one requester is valid, it is granted regardless of the pointer.
  - The pointer updates only on acceptance.
- Requesters must hold a/b/op stable while valid && !ready. A request may be withdrawn before it is accepted; no state changes.

## Timing
- Reset (asynchronous, immediate) clears all outputs and registers to 0: state IDLE, pointer 1, alu_* 0, rsp_* 0, readys 0.
- Reset mid-EXEC or mid-RESP discards the operation; no response is emitted.
- Latency: a request accepted on edge T gives rsp_valid high starting at edge T+SETTLE.
- The ALU sees new operands for exactly SETTLE full cycles before capture.
- Minimum issue interval is SETTLE+2 cycles (1 IDLE, SETTLE EXEC, 1 RESP with rsp_ready high).
- rsp_ready high while not in RESP has no effect.
- reqN_ready depends only on state, pointer and the valids. There is no combinational path from rsp_ready or alu_* inputs.

## Structure
- Package alu_sched_pkg holds:
  - Op encodings: OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111.
  - State enum {IDLE, EXEC, RESP}.
  - The cnt width: 4 bits.
- Sub-module rr_arb2 is a 2-requester round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], accept.
  - Outputs: gnt[1:0] (one-hot/zero), gnt_id.
  - It owns the last-granted pointer.

## Test plan
- req0 ADD a=5, b=7, SETTLE=4, accepted on edge T → rsp_valid rises at T+4, rsp_id=0, rsp_result=12, rsp_zero=0, rsp_err=0; ready low throughout EXEC/RESP.
- After reset, req0 (AND 512312 & 312312) and req1 (OR of the same operands) are held valid together with rsp_ready=1 → order 0,1,0,1. Results are 311608 and 513016.
- req1 SUB 7891932−318902 → 7573030. SUB 65512−65512 → result 0, rsp_zero=1.
- SLT a=−123213, b=412412 → rsp_result=1. Op 3'b011 → rsp_result=0, rsp_err=1, all flags 0.
- rsp_ready held low for 10 cycles in RESP, with req1 valid throughout → rsp_* constant, req1_ready=0. req1 is accepted the cycle after rsp_ready rises and the FSM reaches IDLE.
- rst_n pulsed low mid-EXEC → all outputs 0 immediately. After release, a pending req0 is accepted with the pointer at its reset value, and no stale response appears.
